// File: rtl/button_debounce_array_pkg.sv
// Shared constants for the front-panel button debouncer.
// Package button_pkg: default timing windows and the idle (released) level.
package button_pkg;

    localparam int unsigned BTN_STABLE_CYCLES_DEF = 200000;
    localparam int unsigned BTN_LONG_CYCLES_DEF   = 10000000;
    localparam logic        BTN_RELEASED          = 1'b1;

endpackage

// File: rtl/button_debounce_array_if.sv
// Button bundle between the raw pins/consumer and the debouncer array.
// master: drives raw buttons, consumes events. slave: the debouncer.
interface button_debounce_array_if #(
    parameter int unsigned N_CH = 4
);

    logic [N_CH-1:0] i_Btn;
    logic [N_CH-1:0] o_Level;
    logic [N_CH-1:0] o_Press;
    logic [N_CH-1:0] o_Release;
    logic [N_CH-1:0] o_Long;

    modport master (
        output i_Btn,
        input  o_Level,
        input  o_Press,
        input  o_Release,
        input  o_Long
    );

    modport slave (
        input  i_Btn,
        output o_Level,
        output o_Press,
        output o_Release,
        output o_Long
    );

endinterface

// File: rtl/button_debounce_array_channel.sv
// One debounced button channel: 2-flop synchroniser, stability window,
// debounced level, registered press/release pulses.
// Optional long-press one-shot built when BUTTON_LONG_PRESS_EN is defined;
// otherwise o_Long is tied low and LONG_CYCLES is ignored.
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = BTN_STABLE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = BTN_LONG_CYCLES_DEF
) (
    input  logic i_Clock,
    input  logic i_Rst,
    input  logic i_Btn,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

    logic             q1;
    logic             q2;
    logic             s_d;
    logic             lvl;
    logic             lvl_d;
    logic             lvl_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Synchronise the asynchronous pin into the clock domain.
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            q1 <= BTN_RELEASED;
            q2 <= BTN_RELEASED;
        end else begin
            q1 <= i_Btn;
            q2 <= q1;
        end
    end

    // Stability window: restart on any change, accept the sample once it has held.
    always_comb begin
        cnt_next = cnt;
        lvl_next = lvl;
        if (q2 != s_d) begin
            cnt_next = '0;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt_next = cnt + CNT_W'(1);
            end
            if (cnt == CNT_HIT) begin
                lvl_next = q2;
            end
        end
    end

    // Window state, debounced level and edge pulses (pulses trail the level by one edge).
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            s_d       <= BTN_RELEASED;
            cnt       <= '0;
            lvl       <= BTN_RELEASED;
            lvl_d     <= BTN_RELEASED;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
        end else begin
            s_d       <= q2;
            cnt       <= cnt_next;
            lvl       <= lvl_next;
            lvl_d     <= lvl;
            o_Press   <= lvl_d & ~lvl;
            o_Release <= ~lvl_d & lvl;
        end
    end

    assign o_Level = lvl;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned       LCNT_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_HIT = LCNT_W'(LONG_CYCLES - 1);

    logic [LCNT_W-1:0] lcnt;
    logic              long_hit;

    // Hold timer; saturation keeps the one-shot to a single pulse per press.
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            lcnt     <= '0;
            long_hit <= 1'b0;
            o_Long   <= 1'b0;
        end else begin
            if (lvl) begin
                lcnt <= '0;
            end else if (lcnt != LCNT_MAX) begin
                lcnt <= lcnt + LCNT_W'(1);
            end
            long_hit <= ~lvl & (lcnt == LCNT_HIT);
            o_Long   <= long_hit;
        end
    end
`else
    assign o_Long = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel push-button debouncer: N_CH independent channels.
// Long-press detection is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce_array
    import button_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = BTN_STABLE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = BTN_LONG_CYCLES_DEF
) (
    input  logic                    i_Clock,
    input  logic                    i_Rst,
    button_debounce_array_if.slave  bus
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        button_debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_channel (
            .i_Clock   (i_Clock),
            .i_Rst     (i_Rst),
            .i_Btn     (bus.i_Btn[ch]),
            .o_Level   (bus.o_Level[ch]),
            .o_Press   (bus.o_Press[ch]),
            .o_Release (bus.o_Release[ch]),
            .o_Long    (bus.o_Long[ch])
        );
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Self-checking bench for button_debounce_array (N_CH=2, STABLE=8, LONG=20).
// Reference model: a two-edge input delay followed by run-length counting of
// the delayed samples; the level flips when a run reaches STABLE+1 samples.
module tb_button_debounce_array;

    localparam int unsigned N = 2;
    localparam int unsigned S = 8;
    localparam int unsigned L = 20;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    button_debounce_array_if #(.N_CH(N)) bus ();

    button_debounce_array #(
        .N_CH          (N),
        .STABLE_CYCLES (S),
        .LONG_CYCLES   (L)
    ) dut (
        .i_Clock (clk),
        .i_Rst   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [N-1:0] dq[$];
    logic [N-1:0] v;
    logic [N-1:0] last, m_lvl, m_lvl_d, m_press, m_rel, m_long;
    int unsigned  run[N];
    int unsigned  lr[N];
    int unsigned  lr_d[N];

    always @(posedge clk) begin
        if (rst) begin
            dq.delete();
            dq.push_back('1);
            dq.push_back('1);
            last    = '1;
            m_lvl   = '1;
            m_lvl_d = '1;
            m_press = '0;
            m_rel   = '0;
            m_long  = '0;
            for (int c = 0; c < N; c++) begin
                run[c]  = 1;
                lr[c]   = 0;
                lr_d[c] = 0;
            end
        end else begin
            v = dq.pop_front();
            dq.push_back(bus.i_Btn);
            m_press = m_lvl_d & ~m_lvl;
            m_rel   = ~m_lvl_d & m_lvl;
            m_lvl_d = m_lvl;
            for (int c = 0; c < N; c++) begin
                m_long[c] = (lr_d[c] == L);
                lr_d[c]   = lr[c];
                run[c]    = (v[c] == last[c]) ? run[c] + 1 : 1;
                last[c]   = v[c];
                if (run[c] == S + 1) m_lvl[c] = v[c];
                lr[c] = m_lvl[c] ? 0 : lr[c] + 1;
            end
        end
    end

    logic [N-1:0]   exp_long;
    logic [4*N-1:0] got, exp_v;
    assign exp_long = LONG_EN ? m_long : '0;
    assign got      = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
    assign exp_v    = {m_lvl, m_press, m_rel, exp_long};

    // Apply a button pattern at the falling edge, let one rising edge pass,
    // return at the next falling edge ready to observe.
    task automatic tick(input logic [N-1:0] b);
        bus.i_Btn = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int unsigned pulses = 0;
        rst = 1'b1;
        repeat (3) tick('1);
        checks++;
        if (got !== {{N{1'b1}}, {(3*N){1'b0}}}) begin
            errors++;
            $display("FAIL reset_values got %b exp %b", got, {{N{1'b1}}, {(3*N){1'b0}}});
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick('1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_idle i=%0d got %b exp %b", i, got, exp_v);
            end
            pulses += $countones(bus.o_Press | bus.o_Release | bus.o_Long);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_idle_pulses got %0d exp 0", pulses);
        end
    endtask

    task automatic test_clean_press();
        int lat_lvl = -1;
        int lat_press = -1;
        int press_cnt = 0;
        int other = 0;
        repeat (10) tick('1);
        for (int i = 0; i < int'(S) + 10; i++) begin
            tick(2'b10);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL clean_press i=%0d got %b exp %b", i, got, exp_v);
            end
            if (lat_lvl < 0 && bus.o_Level[0] === 1'b0) lat_lvl = i;
            if (bus.o_Press[0] === 1'b1) begin
                if (lat_press < 0) lat_press = i;
                press_cnt++;
            end
            if ((bus.o_Press[1] | bus.o_Release[1] | bus.o_Release[0]) !== 1'b0) other++;
        end
        checks++;
        if (lat_lvl !== int'(S) + 2) begin
            errors++;
            $display("FAIL clean_level_latency got %0d exp %0d", lat_lvl, S + 2);
        end
        checks++;
        if (lat_press !== int'(S) + 3) begin
            errors++;
            $display("FAIL clean_press_latency got %0d exp %0d", lat_press, S + 3);
        end
        checks++;
        if (press_cnt !== 1) begin
            errors++;
            $display("FAIL clean_press_width got %0d exp 1", press_cnt);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL clean_quiet_channels got %0d exp 0", other);
        end
        for (int i = 0; i < int'(S) + 6; i++) begin
            tick('1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL clean_release i=%0d got %b exp %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        int press_cnt = 0;
        int press_at = -1;
        int rel_cnt = 0;
        logic b0;
        for (int i = 0; i < 60; i++) begin
            b0 = (i < 30) ? (((i / 3) % 2) != 0) : 1'b0;
            tick({1'b1, b0});
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL bounce i=%0d got %b exp %b", i, got, exp_v);
            end
            if (bus.o_Press[0] === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
            if (bus.o_Release[0] === 1'b1) rel_cnt++;
        end
        checks++;
        if (press_cnt !== 1) begin
            errors++;
            $display("FAIL bounce_press_count got %0d exp 1", press_cnt);
        end
        checks++;
        if (press_at !== 30 + int'(S) + 3) begin
            errors++;
            $display("FAIL bounce_press_time got %0d exp %0d", press_at, 30 + S + 3);
        end
        checks++;
        if (rel_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_release_count got %0d exp 0", rel_cnt);
        end
        for (int i = 0; i < int'(S) + 6; i++) begin
            tick('1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL bounce_release i=%0d got %b exp %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_long_press();
        int fall = -1;
        int long_at = -1;
        int long_cnt = 0;
        int rel_cnt = 0;
        int exp_at;
        for (int i = 0; i < int'(S) + 43; i++) begin
            tick(2'b01);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL long_hold i=%0d got %b exp %b", i, got, exp_v);
            end
            if (fall < 0 && bus.o_Level[1] === 1'b0) fall = i;
            if (bus.o_Long[1] === 1'b1) begin
                long_cnt++;
                if (long_at < 0) long_at = i;
            end
        end
        exp_at = LONG_EN ? fall + int'(L) + 1 : -1;
        checks++;
        if (long_cnt !== (LONG_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL long_count got %0d exp %0d", long_cnt, LONG_EN ? 1 : 0);
        end
        checks++;
        if (long_at !== exp_at) begin
            errors++;
            $display("FAIL long_time got %0d exp %0d", long_at, exp_at);
        end
        for (int i = 0; i < int'(S) + 8; i++) begin
            tick('1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL long_release i=%0d got %b exp %b", i, got, exp_v);
            end
            if (bus.o_Release[1] === 1'b1) rel_cnt++;
            if (bus.o_Long[1] === 1'b1) long_cnt++;
        end
        checks++;
        if (rel_cnt !== 1) begin
            errors++;
            $display("FAIL long_release_count got %0d exp 1", rel_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int both_press = -1;
        int both_rel = -1;
        for (int i = 0; i < int'(S) + 6; i++) begin
            tick('0);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL simul_press i=%0d got %b exp %b", i, got, exp_v);
            end
            if (both_press < 0 && bus.o_Press === 2'b11) both_press = i;
        end
        for (int i = 0; i < int'(S) + 6; i++) begin
            tick('1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL simul_release i=%0d got %b exp %b", i, got, exp_v);
            end
            if (both_rel < 0 && bus.o_Release === 2'b11) both_rel = i;
        end
        checks++;
        if (both_press !== int'(S) + 3) begin
            errors++;
            $display("FAIL simul_press_time got %0d exp %0d", both_press, S + 3);
        end
        checks++;
        if (both_rel !== int'(S) + 3) begin
            errors++;
            $display("FAIL simul_release_time got %0d exp %0d", both_rel, S + 3);
        end
    endtask

    task automatic test_reset_mid_window();
        int early = 0;
        int press_at = -1;
        int press_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(2'b10);
            if (bus.o_Press !== 2'b00 || bus.o_Level !== 2'b11) early++;
        end
        rst = 1'b1;
        tick(2'b10);
        checks++;
        if (got !== {{N{1'b1}}, {(3*N){1'b0}}}) begin
            errors++;
            $display("FAIL midreset_values got %b exp %b", got, {{N{1'b1}}, {(3*N){1'b0}}});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(2'b10);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL midreset_hold i=%0d got %b exp %b", i, got, exp_v);
            end
            if (bus.o_Press[0] === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL midreset_early got %0d exp 0", early);
        end
        checks++;
        if (press_at !== int'(S) + 3 || press_cnt !== 1) begin
            errors++;
            $display("FAIL midreset_press got t=%0d n=%0d exp t=%0d n=1", press_at, press_cnt, S + 3);
        end
        for (int i = 0; i < int'(S) + 6; i++) begin
            tick('1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL midreset_release i=%0d got %b exp %b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] b = '1;
        int unsigned  hold[N];
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    b[c]    = ~b[c];
                    hold[c] = $urandom_range(1, 3 * S);
                end else begin
                    hold[c]--;
                end
            end
            tick(b);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random i=%0d btn %b got %b exp %b", i, b, got, exp_v);
            end
        end
    endtask

    initial begin
        bus.i_Btn = '1;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_back_to_back();
        test_reset_mid_window();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
